clk_en_ctrl: RTL and testbench

Clock-enable scheduler for the board top level's BUFGCE-gated SoC clock. Generates the single-cycle CE pattern that divides the 100 MHz board clock by a runtime-programmable ratio, accepts ratio-change commands through a pulse/ack handshake, and applies each new ratio only on a period boundary so the gated clock never emits a runt pulse. Also sequences the SoC reset so the core starts only after a fixed number of clean gated edges.

---
 rtl/clk_en_ctrl_if.sv | 23 ++
 rtl/clk_en_ctrl.sv | 139 +++++++++++++
 tb/tb_clk_en_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/clk_en_ctrl_if.sv
// rtl/clk_en_ctrl_if.sv - ratio-change command handshake between the board top and clk_en_ctrl
interface clk_en_ctrl_if #(
  parameter int DIV_W = 8
);
  logic             div_req;
  logic [DIV_W-1:0] div_val;
  logic             div_ack;
  logic             busy;

  modport master (
    output div_req,
    output div_val,
    input  div_ack,
    input  busy
  );

  modport slave (
    input  div_req,
    input  div_val,
    output div_ack,
    output busy
  );
endinterface

// File: rtl/clk_en_ctrl.sv
// rtl/clk_en_ctrl.sv - BUFGCE clock-enable divider with runt-free ratio switching and SoC reset sequencing
// Define CLK_EN_CTRL_RESEQ_EN to re-run the SoC reset hold after every ratio change.
module clk_en_ctrl #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int RST_HOLD    = 16
) (
  input  logic             clk,
  input  logic             resetn,
  clk_en_ctrl_if.slave     cmd,
  output logic             ce,
  output logic             soc_reset,
  output logic             locked,
  output logic [DIV_W-1:0] cur_div
);

  localparam logic [1:0] ST_HOLD   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;
  localparam logic [1:0] ST_REHOLD = 2'd3;

  localparam int               HC_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HC_W-1:0]  HC_LAST = HC_W'(RST_HOLD - 1);
  localparam logic [HC_W-1:0]  HC_ONE  = HC_W'(1);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             ce_q, ce_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic             soc_reset_q, soc_reset_d;
  logic             locked_q, locked_d;
  logic             busy_q, busy_d;
  logic             div_ack_q, div_ack_d;

  logic             period_end;
  logic             hold_pulse;
  logic             hold_done;
  logic [DIV_W-1:0] req_div;

  always_comb begin
    period_end = (cnt_q == (cur_div_q - DIV_ONE));
    req_div    = (cmd.div_val == '0) ? DIV_ONE : cmd.div_val;
    // The ce registered on the switch edge (ack cycle) is the last old-ratio
    // pulse and must not count toward the new-ratio reset hold.
    hold_pulse = ce_q && !div_ack_q;
    hold_done  = hold_pulse && (hold_cnt_q == HC_LAST);

    state_d     = state_q;
    cur_div_d   = cur_div_q;
    pend_div_d  = pend_div_q;
    hold_cnt_d  = hold_cnt_q;
    soc_reset_d = soc_reset_q;
    div_ack_d   = 1'b0;

    if (period_end) begin
      cnt_d = '0;
      ce_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + DIV_ONE;
      ce_d  = 1'b0;
    end

    case (state_q)
      ST_HOLD, ST_REHOLD: begin
        soc_reset_d = !hold_done;
        if (hold_pulse) begin
          if (hold_done) begin
            hold_cnt_d = '0;
            state_d    = ST_RUN;
          end else begin
            hold_cnt_d = hold_cnt_q + HC_ONE;
          end
        end
      end
      ST_RUN: begin
        soc_reset_d = 1'b0;
        if (cmd.div_req) begin
          pend_div_d = req_div;
          state_d    = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        // Swap only on the edge that registers the final old-ratio ce, so the
        // next period starts cleanly at the new ratio with no runt.
        if (period_end) begin
          cur_div_d = pend_div_q;
          div_ack_d = 1'b1;
`ifdef CLK_EN_CTRL_RESEQ_EN
          state_d   = ST_REHOLD;
`else
          state_d   = ST_RUN;
`endif
        end
      end
      default: state_d = ST_HOLD;
    endcase

    locked_d = (state_d == ST_RUN);
    busy_d   = !locked_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      ce_q        <= 1'b0;
      cur_div_q   <= DIV_RST;
      pend_div_q  <= DIV_RST;
      hold_cnt_q  <= '0;
      soc_reset_q <= 1'b1;
      locked_q    <= 1'b0;
      busy_q      <= 1'b1;
      div_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ce_q        <= ce_d;
      cur_div_q   <= cur_div_d;
      pend_div_q  <= pend_div_d;
      hold_cnt_q  <= hold_cnt_d;
      soc_reset_q <= soc_reset_d;
      locked_q    <= locked_d;
      busy_q      <= busy_d;
      div_ack_q   <= div_ack_d;
    end
  end

  assign ce          = ce_q;
  assign soc_reset   = soc_reset_q;
  assign locked      = locked_q;
  assign cur_div     = cur_div_q;
  assign cmd.div_ack = div_ack_q;
  assign cmd.busy    = busy_q;

endmodule

// File: tb/tb_clk_en_ctrl.sv
// tb/tb_clk_en_ctrl.sv - randomized self-checking bench for clk_en_ctrl against a timestamp model
module tb_clk_en_ctrl;

  localparam int DIV_W       = 8;
  localparam int DEFAULT_DIV = 2;
  localparam int RST_HOLD    = 16;
`ifdef CLK_EN_CTRL_RESEQ_EN
  localparam bit RESEQ = 1'b1;
`else
  localparam bit RESEQ = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             resetn;
  logic             ce;
  logic             soc_reset;
  logic             locked;
  logic [DIV_W-1:0] cur_div;

  clk_en_ctrl_if #(.DIV_W(DIV_W)) cmd_if ();

  clk_en_ctrl #(
    .DIV_W      (DIV_W),
    .DEFAULT_DIV(DEFAULT_DIV),
    .RST_HOLD   (RST_HOLD)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .cmd      (cmd_if),
    .ce       (ce),
    .soc_reset(soc_reset),
    .locked   (locked),
    .cur_div  (cur_div)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: edges are numbered from reset release; ce edges, hold release
  // and reset reassertion are tracked as absolute edge timestamps.
  int n;
  int m_mode;   // 0 = reset held, 1 = running, 2 = waiting for boundary
  int m_div, m_pend, m_next, m_rel, m_rise;
  int e_ce, e_ack, e_soc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, n, got, exp);
    end
  endtask

  task automatic model_reset();
    n      = 0;
    m_mode = 0;
    m_div  = DEFAULT_DIV;
    m_pend = DEFAULT_DIV;
    m_next = DEFAULT_DIV;
    m_rel  = RST_HOLD * DEFAULT_DIV + 1;
    m_rise = 0;
    e_ce   = 0;
    e_ack  = 0;
    e_soc  = 1;
  endtask

  task automatic model_edge(input bit req, input logic [DIV_W-1:0] val);
    n++;
    e_ce  = (n == m_next) ? 1 : 0;
    e_ack = 0;
    case (m_mode)
      1: if (req) begin
        m_pend = (val == 0) ? 1 : int'(val);
        m_mode = 2;
      end
      2: if (e_ce == 1) begin
        m_div = m_pend;
        e_ack = 1;
        if (RESEQ) begin
          m_mode = 0;
          m_rise = n + 1;
          m_rel  = n + RST_HOLD * m_div + 1;
        end else begin
          m_mode = 1;
        end
      end
      default: if (n == m_rel) m_mode = 1;
    endcase
    if (e_ce == 1) m_next = n + m_div;
    e_soc = (m_mode == 0 && n >= m_rise) ? 1 : 0;
  endtask

  task automatic check_all();
    chk("ce",        32'(ce),          32'(e_ce));
    chk("div_ack",   32'(cmd_if.div_ack), 32'(e_ack));
    chk("soc_reset", 32'(soc_reset),   32'(e_soc));
    chk("locked",    32'(locked),      32'(m_mode == 1));
    chk("busy",      32'(cmd_if.busy), 32'(m_mode != 1));
    chk("cur_div",   32'(cur_div),     32'(m_div));
  endtask

  task automatic check_reset_vals();
    chk("rst_ce",        32'(ce),             32'd0);
    chk("rst_div_ack",   32'(cmd_if.div_ack), 32'd0);
    chk("rst_soc_reset", 32'(soc_reset),      32'd1);
    chk("rst_locked",    32'(locked),         32'd0);
    chk("rst_busy",      32'(cmd_if.busy),    32'd1);
    chk("rst_cur_div",   32'(cur_div),        32'(DEFAULT_DIV));
  endtask

  // Called at posedge+1: drive inputs, take one edge, then compare.
  task automatic cyc(input bit req, input logic [DIV_W-1:0] val);
    cmd_if.div_req = req;
    cmd_if.div_val = val;
    @(posedge clk);
    model_edge(req, val);
    #1;
    check_all();
    cmd_if.div_req = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) cyc(1'b0, '0);
  endtask

  task automatic wait_run(input int budget);
    int k;
    k = 0;
    while (m_mode != 1 && k < budget) begin
      cyc(1'b0, '0);
      k++;
    end
    if (m_mode != 1) chk("wait_run_timeout", 32'(locked), 32'd1);
  endtask

  initial begin
    logic [DIV_W-1:0] v;
    bit               r;

    resetn         = 1'b0;
    cmd_if.div_req = 1'b0;
    cmd_if.div_val = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    resetn = 1'b1;

    // Requests during the initial hold, including the release edge, are ignored.
    for (int i = 1; i <= 40; i++) cyc(i == 5 || i == 20 || i == 33, 8'd7);

    // Change to 5 mid-period, with a second request during the switch.
    idle(1);
    cyc(1'b1, 8'd5);
    cyc(1'b1, 8'd9);
    idle(14);
    wait_run(400);

    // Zero clamps to 1, then 3.
    cyc(1'b1, 8'd0);
    wait_run(50);
    idle(5);
    cyc(1'b1, 8'd3);
    wait_run(50);
    idle(8);

    // Same ratio as current still runs the full switch.
    cyc(1'b1, 8'd3);
    wait_run(400);
    idle(4);

    for (int i = 0; i < 2000; i++) begin
      r = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) v = DIV_W'($urandom_range(0, 255));
      else v = DIV_W'($urandom_range(0, 9));
      cyc(r, v);
    end

    // Asynchronous reset in the middle of a long switch.
    wait_run(5000);
    cyc(1'b1, 8'd8);
    wait_run(400);
    idle(2);
    cyc(1'b1, 8'd4);
    idle(2);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_vals();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    model_reset();
    resetn = 1'b1;
    idle(60);
    cyc(1'b1, 8'd4);
    idle(80);
    wait_run(400);
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
